// File: rtl/phase_a_seq.sv
// Initiator-side sequencer for phase_a: loads an operand, runs N launch/wait/capture
// passes through phase_a, then hands the result downstream with a watchdog error flag.
module phase_a_seq #(
  parameter int Size    = 3072,
  parameter int ITER_W  = 8,
  parameter int TIMEOUT = 32,
  parameter int TO_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [Size-1:0]   in_a,
  input  logic [ITER_W-1:0] in_iter,
  output logic [Size-1:0]   pa_a,
  output logic              pa_en,
  input  logic [Size-1:0]   pa_new_a,
  input  logic              pa_en_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Size-1:0]   out_a,
  output logic              out_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH0 = 3'd1,
    S_LAUNCH1 = 3'd2,
    S_WAIT    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            r_state, w_state_next;
  logic [Size-1:0]   r_op, w_op_next;
  logic [ITER_W-1:0] r_cnt, w_cnt_next;
  logic [TO_W-1:0]   r_to_cnt, w_to_cnt_next;
  logic              r_pa_en, w_pa_en_next;
  logic              r_out_err, w_out_err_next;
  logic              w_to_last;

  // Last WAIT cycle before the watchdog fires: the counter would reach TIMEOUT on this edge.
  assign w_to_last = (r_to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_cnt     <= '0;
      r_to_cnt  <= '0;
      r_pa_en   <= 1'b0;
      r_out_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_op      <= w_op_next;
      r_cnt     <= w_cnt_next;
      r_to_cnt  <= w_to_cnt_next;
      r_pa_en   <= w_pa_en_next;
      r_out_err <= w_out_err_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_op_next      = r_op;
    w_cnt_next     = r_cnt;
    w_to_cnt_next  = r_to_cnt;
    w_out_err_next = r_out_err;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_op_next      = in_a;
          w_cnt_next     = in_iter;
          w_to_cnt_next  = '0;
          w_out_err_next = 1'b0;
          w_state_next   = (in_iter == '0) ? S_DONE : S_LAUNCH0;
        end
      end
      S_LAUNCH0: w_state_next = S_LAUNCH1;
      S_LAUNCH1: w_state_next = S_WAIT;
      S_WAIT: begin
        // A completion on the same cycle as the watchdog expiry takes priority.
        if (pa_en_out) begin
          w_op_next     = pa_new_a;
          w_cnt_next    = r_cnt - 1'b1;
          w_to_cnt_next = '0;
          w_state_next  = (r_cnt == ITER_W'(1)) ? S_DONE : S_LAUNCH0;
        end else if (w_to_last) begin
          w_to_cnt_next  = '0;
          w_out_err_next = 1'b1;
          w_state_next   = S_DONE;
        end else begin
          w_to_cnt_next = r_to_cnt + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // pa_en is registered: high for exactly the two launch states.
    w_pa_en_next = (w_state_next == S_LAUNCH0) || (w_state_next == S_LAUNCH1);
  end

  assign pa_a      = r_op;
  assign out_a     = r_op;
  assign pa_en     = r_pa_en;
  assign out_err   = r_out_err;
  assign out_valid = (r_state == S_DONE);
  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_phase_a_seq.sv
// Self-checking bench for phase_a_seq: behavioural phase_a responder plus directed
// and randomized transactions checked against result/latency expectations.
module tb_phase_a_seq;
  localparam int W   = 64;
  localparam int IW  = 8;
  localparam int TMO = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          pa_en_out = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  pa_new_a = '0;
  logic [IW-1:0] in_iter = '0;
  logic          in_ready, pa_en, out_valid, out_err, busy;
  logic [W-1:0]  pa_a, out_a;

  phase_a_seq #(.Size(W), .ITER_W(IW), .TIMEOUT(TMO), .TO_W(6)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_iter(in_iter),
    .pa_a(pa_a), .pa_en(pa_en), .pa_new_a(pa_new_a), .pa_en_out(pa_en_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_err(out_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  // phase_a responder configuration and observations
  logic [W-1:0] m_delta = 64'd1;
  int           m_lat = 17;
  bit           m_respond = 1'b1;
  bit           m_spur = 1'b0;
  bit           m_pend = 1'b0;
  bit           m_prev_en = 1'b0;
  int           m_timer = 0;
  logic [W-1:0] m_a = '0;
  int           m_pulses_out = 0;
  int           m_pulse_cyc = 0;
  int           m_en_last = 0;
  int           s_en_rises = 0;
  int           s_len_bad = 0;
  int           s_stab_bad = 0;
  int           s_run = 0;

  // Responds L cycles after the first pa_en cycle with the operand sampled at launch plus delta.
  always @(negedge clk) begin
    cyc++;
    pa_en_out = 1'b0;
    if (pa_en) begin
      m_en_last = cyc;
      s_run++;
      if (!m_prev_en) begin
        s_en_rises++;
        m_pend  = 1'b1;
        m_timer = 0;
        m_a     = pa_a;
      end
    end else if (m_prev_en) begin
      if (s_run != 2) s_len_bad++;
      s_run = 0;
    end
    if (m_pend) begin
      m_timer++;
      if (busy && !out_valid && (pa_a !== m_a)) s_stab_bad++;
      if (m_respond && m_timer == m_lat) begin
        pa_en_out = 1'b1;
        pa_new_a  = m_a + m_delta;
        m_pend    = 1'b0;
        m_pulses_out++;
        m_pulse_cyc = cyc;
      end
    end
    if (m_spur) begin
      pa_en_out = 1'b1;
      pa_new_a  = {$urandom, $urandom};
      m_spur    = 1'b0;
    end
    m_prev_en = pa_en;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic [W-1:0] a, input int iter, input int lat,
                         input logic [W-1:0] d, input bit resp, input int rdy_dly,
                         input bit spur);
    logic [W-1:0] exp_a;
    logic [W-1:0] held;
    bit           exp_err;
    int           exp_p, c0, cv, n;
    m_lat = lat; m_delta = d; m_respond = resp;
    s_en_rises = 0; s_len_bad = 0; s_stab_bad = 0;
    if (iter == 0) begin
      exp_a = a; exp_err = 1'b0; exp_p = 0;
    end else if (resp && lat <= TMO + 2) begin
      exp_a = a;
      for (int i = 0; i < iter; i++) exp_a = exp_a + d;
      exp_err = 1'b0; exp_p = iter;
    end else begin
      exp_a = a; exp_err = 1'b1; exp_p = 1;
    end
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_a = a; in_iter = IW'(iter); c0 = cyc;
    step();
    in_valid = 1'b0; in_a = {$urandom, $urandom}; in_iter = IW'($urandom);
    n = 0;
    while (!out_valid && n < 3000) begin step(); n++; end
    chk("out_valid_seen", 64'(out_valid), 64'd1);
    cv = cyc;
    chk("out_a", out_a, exp_a);
    chk("out_err", 64'(out_err), 64'(exp_err));
    chk("pa_en_pulses", 64'(s_en_rises), 64'(exp_p));
    chk("pa_en_len", 64'(s_len_bad), 64'd0);
    chk("pa_a_stable", 64'(s_stab_bad), 64'd0);
    if (iter == 0) chk("bypass_lat", 64'(cv - c0), 64'd1);
    else if (!exp_err) chk("capture_lat", 64'(cv - m_pulse_cyc), 64'd1);
    else chk("timeout_wait", 64'(cv - m_en_last - 1), 64'(TMO));
    held = out_a;
    for (int i = 0; i < rdy_dly; i++) begin
      if (spur && i == 3) m_spur = 1'b1;
      step();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_out_a", out_a, held);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_drop", 64'(out_valid), 64'd0);
    chk("in_ready_back", 64'(in_ready), 64'd1);
    $display("txn a=%0h iter=%0d lat=%0d resp=%0d -> out_a=%0h err=%0d",
             a, iter, lat, resp, out_a, out_err);
  endtask

  initial begin
    int n, k;
    repeat (3) step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pa_en", 64'(pa_en), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_out_a", out_a, 64'd0);
    rst = 1'b0;
    step();

    run_txn(64'h0000_0000_0000_0123, 1, 17, 64'd5, 1'b1, 0, 1'b0);
    run_txn(64'h1234_5678_9abc_def0, 3, 17, 64'd1, 1'b1, 1, 1'b0);
    run_txn(64'h0000_0000_0000_DEAD, 0, 17, 64'd1, 1'b1, 0, 1'b0);
    run_txn(64'h0bad_cafe_0000_0042, 1, 17, 64'd1, 1'b0, 0, 1'b0);
    run_txn(64'h5555_aaaa_5555_aaaa, 2, 9, 64'd7, 1'b1, 10, 1'b1);
    run_txn(64'h0000_0000_0000_1000, 2, TMO + 2, 64'd3, 1'b1, 0, 1'b0);
    run_txn(64'h0000_0000_0000_2000, 2, TMO + 3, 64'd3, 1'b1, 2, 1'b0);

    // Reset in WAIT of pass 2 of 4; the in-flight completion must be ignored.
    m_lat = 17; m_delta = 64'd1; m_respond = 1'b1; s_en_rises = 0;
    in_valid = 1'b1; in_a = 64'h77; in_iter = 8'd4;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!(s_en_rises == 2 && !pa_en) && n < 500) begin step(); n++; end
    chk("mid_reach_pass2", 64'(s_en_rises), 64'd2);
    step(); step();
    rst = 1'b1; k = m_pulses_out;
    step();
    chk("mid_rst_pa_en", 64'(pa_en), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    n = 0;
    while (m_pulses_out == k && n < 100) begin step(); n++; end
    chk("late_pulse_sent", 64'(m_pulses_out), 64'(k + 1));
    step();
    chk("late_busy", 64'(busy), 64'd0);
    chk("late_out_valid", 64'(out_valid), 64'd0);
    chk("late_out_a", out_a, 64'd0);
    $display("txn mid-run reset -> busy=%0d out_a=%0h", busy, out_a);
    run_txn(64'h0000_0000_0000_0abc, 1, 17, 64'd9, 1'b1, 0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      run_txn({$urandom, $urandom}, $urandom_range(0, 4), $urandom_range(3, 36),
              {$urandom, $urandom}, ($urandom_range(0, 4) != 0),
              $urandom_range(0, 3), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
